// File: rtl/cdc_tx_queue.sv
// CPU-side byte queue feeding the clk1 write port of the TWI clock-domain crossing.
// Issues queued bytes as single-cycle strobes, tracks the crossing handshake and flags stalls/overflows.
module cdc_tx_queue #(
  parameter int DEPTH   = 4,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       cpu_we,
  input  logic [7:0]                 cpu_wd,
  output logic                       cpu_full,
  output logic [$clog2(DEPTH+1)-1:0] cpu_level,
  output logic                       busy,
  output logic                       ovf,
  output logic                       tmo,
  input  logic                       err_clr,
  output logic                       sent,
  output logic                       cdc_wr1,
  output logic [7:0]                 cdc_data1,
  input  logic                       cdc_wait
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [15:0]   CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [SYNC-1:0] sync_q, sync_d;
  logic [15:0]     cnt_q, cnt_d, cnt_inc;
  logic            wr1_q, wr1_d, sent_q, sent_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic [7:0]      data1_q, data1_d;
  logic            wait_s, pop, push, reject, tmo_set;

  assign wait_s  = sync_q[SYNC-1];
  assign pop     = (state_q == IDLE) && (level_q != '0) && !wait_s;
  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign push    = cpu_we && ((level_q != FULL_LVL) || pop);
  assign reject  = cpu_we && !push;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    sync_d = {sync_q[SYNC-2:0], cdc_wait};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr1_d   = 1'b0;
    data1_d = data1_q;
    sent_d  = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          data1_d = mem_q[rd_ptr_q];
          wr1_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (wait_s) begin
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LO: begin
        if (!wait_s) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    // Setting a sticky flag takes priority over clearing it.
    ovf_d = reject  ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    tmo_d = tmo_set ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
  end

  always_ff @(posedge clk1) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sync_q   <= '0;
      cnt_q    <= '0;
      wr1_q    <= 1'b0;
      data1_q  <= '0;
      sent_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      wr1_q    <= wr1_d;
      data1_q  <= data1_d;
      sent_q   <= sent_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  // Storage carries no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk1) begin
    if (push) mem_q[wr_ptr_q] <= cpu_wd;
  end

  assign cpu_full  = (level_q == FULL_LVL);
  assign cpu_level = level_q;
  assign busy      = (state_q != IDLE) || (level_q != '0);
  assign ovf       = ovf_q;
  assign tmo       = tmo_q;
  assign sent      = sent_q;
  assign cdc_wr1   = wr1_q;
  assign cdc_data1 = data1_q;

endmodule

// File: tb/tb_cdc_tx_queue.sv
// Bench for cdc_tx_queue: queue/transfer model checked every cycle, plus directed literal checks.
// A small crossing responder echoes each strobe with a programmable-length wait pulse.
module tb_cdc_tx_queue;
  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 8;

  logic       clk1 = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_wd = 8'h00;
  logic       err_clr = 1'b0;
  logic       cdc_wait = 1'b0;
  logic       cpu_full, busy, ovf, tmo, sent, cdc_wr1;
  logic [2:0] cpu_level;
  logic [7:0] cdc_data1;

  cdc_tx_queue #(.DEPTH(DEPTH), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk1(clk1), .rst(rst), .cpu_we(cpu_we), .cpu_wd(cpu_wd), .cpu_full(cpu_full),
    .cpu_level(cpu_level), .busy(busy), .ovf(ovf), .tmo(tmo), .err_clr(err_clr),
    .sent(sent), .cdc_wr1(cdc_wr1), .cdc_data1(cdc_data1), .cdc_wait(cdc_wait)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad = 0;
  int sent_cnt = 0;
  logic [7:0] strobe_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Crossing responder: wait rises with the strobe and stays high resp_hi cycles.
  bit force_en = 1'b0;
  bit force_val = 1'b0;
  int resp_hi = 3;
  initial begin
    int left;
    left = 0;
    forever begin
      @(posedge clk1);
      #3;
      if (force_en) begin
        cdc_wait = force_val;
        left = 0;
      end else if (cdc_wr1 && resp_hi != 0) begin
        cdc_wait = 1'b1;
        left = resp_hi;
      end else if (left > 0) begin
        left--;
        cdc_wait = (left != 0);
      end else begin
        cdc_wait = 1'b0;
      end
    end
  end

  // Model: byte queue plus transfer phase (0 idle, 1 strobe, 2 await rise, 3 await fall).
  logic [7:0] mq[$];
  int         ph = 0;
  int         el = 0;
  bit         hist[SYNC];
  bit         m_wr1 = 0, m_sent = 0, m_ovf = 0, m_tmo = 0;
  logic [7:0] m_data = 8'h00;

  task automatic model_step();
    bit ws, pop, ovf_set, tmo_set;
    int sz;
    if (!rst) begin
      mq.delete();
      ph = 0; el = 0;
      m_wr1 = 0; m_sent = 0; m_ovf = 0; m_tmo = 0; m_data = 8'h00;
      for (int i = 0; i < SYNC; i++) hist[i] = 0;
      return;
    end
    ws = hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = cdc_wait;
    sz = mq.size();
    pop = (ph == 0) && (sz != 0) && !ws;
    ovf_set = 0; tmo_set = 0; m_wr1 = 0; m_sent = 0;
    if (pop) m_data = mq.pop_front();
    if (cpu_we) begin
      if (sz < DEPTH || pop) mq.push_back(cpu_wd);
      else ovf_set = 1;
    end
    case (ph)
      0: if (pop) begin ph = 1; m_wr1 = 1; end
      1: begin ph = 2; el = 0; end
      2: begin
        if (ws) begin ph = 3; el = 0; end
        else if (el == TIMEOUT - 1) begin tmo_set = 1; ph = 0; end
        else el++;
      end
      default: begin
        if (!ws) begin m_sent = 1; ph = 0; end
        else if (el == TIMEOUT - 1) begin tmo_set = 1; ph = 0; end
        else el++;
      end
    endcase
    m_ovf = ovf_set ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_tmo = tmo_set ? 1'b1 : (err_clr ? 1'b0 : m_tmo);
  endtask

  initial begin
    forever begin
      @(posedge clk1);
      model_step();
      #1;
      check("wr1", cdc_wr1, m_wr1);
      check("data1", cdc_data1, m_data);
      check("sent", sent, m_sent);
      check("ovf", ovf, m_ovf);
      check("tmo", tmo, m_tmo);
      check("level", cpu_level, mq.size());
      check("full", cpu_full, mq.size() == DEPTH);
      check("busy", busy, (ph != 0) || (mq.size() != 0));
      if (cdc_wr1 === 1'b1) strobe_log.push_back(cdc_data1);
      if (sent === 1'b1) sent_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk1);
  endtask

  task automatic push(input logic [7:0] b);
    cpu_we = 1'b1;
    cpu_wd = b;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic wait_sent(input string name, input int target, input int limit);
    for (int i = 0; i < limit && sent_cnt < target; i++) tick();
    check(name, sent_cnt, target);
  endtask

  initial begin
    int base, k;
    logic [7:0] exp2 [4];
    logic [7:0] exp3 [5];
    exp2 = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};

    // 1: reset values, then a single byte round trip
    tick(3);
    check("rst_wr1", cdc_wr1, 0);
    check("rst_data", cdc_data1, 0);
    check("rst_level", cpu_level, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {ovf, tmo, sent}, 0);
    rst = 1'b1;
    tick();
    push(8'hA5);
    check("t1_level", cpu_level, 1);
    tick();
    check("t1_strobe", cdc_wr1, 1);
    check("t1_data", cdc_data1, 8'hA5);
    tick();
    check("t1_strobe_1cyc", cdc_wr1, 0);
    wait_sent("t1_sent", 1, 40);
    tick(2);
    check("t1_sent_once", sent_cnt, 1);
    check("t1_busy", busy, 0);
    check("t1_level_end", cpu_level, 0);

    // 2: fill the queue while the crossing is busy, then drain in order
    force_en = 1'b1; force_val = 1'b1;
    tick(4);
    base = strobe_log.size();
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("t2_full", cpu_full, 1);
    check("t2_level", cpu_level, 4);
    force_en = 1'b0;
    wait_sent("t2_sent", 5, 150);
    check("t2_nstrobe", strobe_log.size(), base + 4);
    for (int i = 0; i < 4 && base + i < strobe_log.size(); i++)
      check("t2_order", strobe_log[base+i], exp2[i]);
    check("t2_ovf", ovf, 0);

    // 3: overflow, clear, then push on full coinciding with a pop
    force_en = 1'b1; force_val = 1'b1;
    tick(4);
    base = strobe_log.size();
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check("t3_level", cpu_level, 4);
    check("t3_ovf", ovf, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_ovf_clr", ovf, 0);
    force_en = 1'b0;
    tick(3);
    push(8'h20);
    check("t3_pp_level", cpu_level, 4);
    check("t3_pp_ovf", ovf, 0);
    check("t3_pp_strobe", cdc_wr1, 1);
    wait_sent("t3_sent", 10, 200);
    for (int i = 0; i < 5 && base + i < strobe_log.size(); i++)
      check("t3_order", strobe_log[base+i], exp3[i]);
    check("t3_nstrobe", strobe_log.size(), base + 5);

    // 4: wait stuck low -> timeout, then next byte issued
    resp_hi = 0;
    tick(2);
    push(8'h30);
    push(8'h31);
    check("t4_strobe", cdc_wr1, 1);
    check("t4_data", cdc_data1, 8'h30);
    tick();
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (tmo === 1'b1) begin k = i; break; end
    end
    check("t4_tmo_cycles", k, 8);
    tick();
    check("t4_next_strobe", cdc_wr1, 1);
    check("t4_next_data", cdc_data1, 8'h31);
    tick(12);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_tmo_clr", tmo, 0);

    // 5: reset while awaiting the wait fall with two bytes queued
    resp_hi = 6;
    tick(2);
    push(8'h50);
    push(8'h51);
    push(8'h52);
    tick(3);
    check("t5_level_pre", cpu_level, 2);
    check("t5_busy_pre", busy, 1);
    rst = 1'b0;
    tick();
    check("t5_rst_wr1", cdc_wr1, 0);
    check("t5_rst_data", cdc_data1, 0);
    check("t5_rst_level", cpu_level, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_flags", {ovf, tmo, sent, cpu_full}, 0);
    tick();
    rst = 1'b1;
    base = strobe_log.size();
    tick(20);
    check("t5_no_strobe", strobe_log.size(), base);

    // 6: err_clr in the same cycle the timeout fires
    resp_hi = 0;
    push(8'h40);
    tick(9);
    check("t6_tmo_before", tmo, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t6_set_wins", tmo, 1);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
